router_ingress_ctrl: RTL and testbench

Ingress controller between the router's byte-wide source interface and its three destination FIFOs. It accepts packets under a valid/busy handshake and decodes the destination from the header byte. It writes header, payload and parity bytes into the selected FIFO with `lfd_state` marking the header, and checks packet parity. It absorbs FIFO back-pressure through a one-byte holding register, so no byte is lost or duplicated.

---
 rtl/router_ingress_ctrl.sv | 158 +++++++++++++++
 tb/tb_router_ingress_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_ingress_ctrl.sv
// Router ingress controller: accepts byte packets from the source, decodes the
// destination from the header, forwards bytes through a one-byte holding
// register into the selected FIFO and checks packet parity.
module router_ingress_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] soft_reset,
  output logic       busy,
  output logic [2:0] write_enb,
  output logic       lfd_state,
  output logic [7:0] data_out,
  output logic       err,
  output logic       parity_done
);

  typedef enum logic [2:0] {
    StDecode,
    StWaitEmpty,
    StLoadData,
    StDrain,
    StDiscard
  } state_e;

  state_e     r_state, w_state_next;
  logic [1:0] r_addr;
  logic [6:0] r_remaining;   // bytes still expected after the header (payload + parity)
  logic [7:0] r_acc;
  logic       r_err;
  logic       r_parity_done;
  logic [7:0] r_hold;
  logic       r_hold_valid;
  logic       r_hold_hdr;

  logic [3:0] w_full4, w_empty4, w_sr4, w_sel4;
  logic       w_full, w_empty, w_sr;
  logic       w_accept, w_write, w_load_hold, w_counting;
  logic [6:0] w_rem_next;

  // Pad the 3-bit flags to 4 so that address 3 indexes a constant 0.
  assign w_full4  = {1'b0, fifo_full};
  assign w_empty4 = {1'b0, fifo_empty};
  assign w_sr4    = {1'b0, soft_reset};
  assign w_sel4   = 4'b0001 << r_addr;
  assign w_full   = w_full4[r_addr];
  assign w_empty  = w_empty4[r_addr];
  assign w_sr     = w_sr4[r_addr] &&
                    (r_state == StWaitEmpty || r_state == StLoadData || r_state == StDrain);

  assign w_accept    = pkt_valid && !busy;
  assign w_counting  = w_accept && (r_state == StLoadData || r_state == StDiscard);
  assign w_rem_next  = w_counting ? (r_remaining - 7'd1) : r_remaining;
  // Discarded headers and discarded bytes never become writable.
  assign w_load_hold = w_accept &&
                       (r_state == StLoadData ||
                        (r_state == StDecode && data_in[1:0] != 2'd3));

  assign data_out    = r_hold;
  assign err         = r_err;
  assign parity_done = r_parity_done;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= StDecode;
    else       r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StDecode: begin
        if (w_accept) begin
          if (data_in[1:0] == 2'd3)          w_state_next = StDiscard;
          else if (w_empty4[data_in[1:0]])   w_state_next = StLoadData;
          else                               w_state_next = StWaitEmpty;
        end
      end
      StWaitEmpty: begin
        if (w_sr)         w_state_next = (w_rem_next == 7'd0) ? StDecode : StDiscard;
        else if (w_empty) w_state_next = StLoadData;
      end
      StLoadData: begin
        if (w_sr)                                     w_state_next =
                                                        (w_rem_next == 7'd0) ? StDecode : StDiscard;
        else if (w_accept && r_remaining == 7'd1)     w_state_next = StDrain;
      end
      StDrain: begin
        if (w_sr || !r_hold_valid || w_write) w_state_next = StDecode;
      end
      StDiscard: begin
        if (r_remaining == 7'd0 || (w_accept && r_remaining == 7'd1)) w_state_next = StDecode;
      end
      default: w_state_next = StDecode;
    endcase
  end

  // Handshake and FIFO write outputs.
  always_comb begin
    busy = 1'b0;
    unique case (r_state)
      StWaitEmpty, StDrain: busy = 1'b1;
      StLoadData:           busy = r_hold_valid && w_full;
      default:              busy = 1'b0;
    endcase
    w_write   = (r_state == StLoadData || r_state == StDrain) && r_hold_valid && !w_full;
    write_enb = w_write ? w_sel4[2:0] : 3'b000;
    lfd_state = w_write && r_hold_hdr;
  end

  // Holding register, packet bookkeeping and parity check.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr        <= 2'd0;
      r_remaining   <= 7'd0;
      r_acc         <= 8'h00;
      r_err         <= 1'b0;
      r_parity_done <= 1'b0;
      r_hold        <= 8'h00;
      r_hold_valid  <= 1'b0;
      r_hold_hdr    <= 1'b0;
    end else begin
      r_parity_done <= 1'b0;
      if (w_accept) begin
        r_hold     <= data_in;
        r_hold_hdr <= (r_state == StDecode);
      end
      if (w_sr)             r_hold_valid <= 1'b0;
      else if (w_load_hold) r_hold_valid <= 1'b1;
      else if (w_write)     r_hold_valid <= 1'b0;

      if (w_accept && r_state == StDecode) begin
        r_addr      <= data_in[1:0];
        r_remaining <= {1'b0, data_in[7:2]} + 7'd1;
        // Expected parity covers the header, so seed with it.
        r_acc       <= data_in;
        r_err       <= 1'b0;
      end else begin
        r_remaining <= w_rem_next;
      end

      if (w_accept && r_state == StLoadData) begin
        if (r_remaining == 7'd1) begin
          if (!w_sr) begin
            r_err         <= (data_in != r_acc);
            r_parity_done <= 1'b1;
          end
        end else begin
          r_acc <= r_acc ^ data_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_ingress_ctrl.sv
// Directed bench for router_ingress_ctrl: inputs driven at the falling edge,
// outputs observed 1 time unit later, FIFO writes logged per cycle.
module tb_router_ingress_ctrl;

  logic       clock, reset, pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full, fifo_empty, soft_reset;
  logic       busy, lfd_state, err, parity_done;
  logic [2:0] write_enb;
  logic [7:0] data_out;

  router_ingress_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .pkt_valid   (pkt_valid),
    .data_in     (data_in),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .soft_reset  (soft_reset),
    .busy        (busy),
    .write_enb   (write_enb),
    .lfd_state   (lfd_state),
    .data_out    (data_out),
    .err         (err),
    .parity_done (parity_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [2:0] we;
    logic       lfd;
    logic [7:0] d;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] exp_q[$];
  int         n_cmp, n_bad, cyc, pd_cnt;
  logic       pd_err;
  logic       o_busy, o_lfd, o_err, o_pd;
  logic [2:0] o_we;
  logic [7:0] o_dout;

  localparam logic [2:0] AllEmpty = 3'b111;
  localparam logic [2:0] None     = 3'b000;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // One clock cycle: drive, observe, log writes, advance to the next falling edge.
  task automatic step(input logic pv, input logic [7:0] d, input logic [2:0] full,
                      input logic [2:0] empty, input logic [2:0] sr);
    wr_t w;
    pkt_valid  = pv;
    data_in    = d;
    fifo_full  = full;
    fifo_empty = empty;
    soft_reset = sr;
    #1;
    o_busy = busy;
    o_we   = write_enb;
    o_lfd  = lfd_state;
    o_dout = data_out;
    o_err  = err;
    o_pd   = parity_done;
    if (write_enb != 3'b000) begin
      w.cyc = cyc;
      w.we  = write_enb;
      w.lfd = lfd_state;
      w.d   = data_out;
      wq.push_back(w);
    end
    if (parity_done) begin
      pd_cnt++;
      pd_err = err;
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, None, AllEmpty, None);
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, None, AllEmpty, None);
  endtask

  task automatic chk_idle_outputs(input string tag);
    check_val(tag, {o_busy, o_we, o_lfd, o_dout, o_err, o_pd}, 32'h0);
  endtask

  // Compare logged writes against exp_q: destination, byte order, header flag on
  // the first byte only, optionally back-to-back cycles. Clears both queues.
  task automatic check_pkt(input string tag, input logic [2:0] we, input bit contig);
    int n;
    check_val({tag, ".count"}, wq.size(), exp_q.size());
    n = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s.data%0d", tag, i), wq[i].d, exp_q[i]);
      check_val($sformatf("%s.we%0d", tag, i), wq[i].we, we);
      check_val($sformatf("%s.lfd%0d", tag, i), wq[i].lfd, (i == 0));
      if (contig) check_val($sformatf("%s.cyc%0d", tag, i), wq[i].cyc - wq[0].cyc, i);
    end
    wq.delete();
    exp_q.delete();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; pd_cnt = 0; pd_err = 1'b0;
    reset = 1'b1; pkt_valid = 1'b0; data_in = 8'h00;
    fifo_full = None; fifo_empty = AllEmpty; soft_reset = None;
    @(negedge clock);

    // Power-on reset.
    idle(2);
    chk_idle_outputs("por");
    reset = 1'b0;
    idle(1);
    chk_idle_outputs("por_release");
    wq.delete();

    // Clean packet to addr 1: header 0x0D (len 3), parity 0x0D^AA^55^01 = F3.
    pd_cnt = 0;
    send(8'h0D); send(8'hAA); send(8'h55); send(8'h01); send(8'hF3);
    check_val("clean.drain_busy", o_busy, 1'b0);
    idle(1);
    check_val("clean.drain_busy1", o_busy, 1'b1);
    check_val("clean.pd_pulse", o_pd, 1'b1);
    idle(2);
    check_val("clean.pd_cnt", pd_cnt, 1);
    check_val("clean.err", pd_err, 1'b0);
    exp_q = '{8'h0D, 8'hAA, 8'h55, 8'h01, 8'hF3};
    check_pkt("clean", 3'b010, 1'b1);

    // Same packet, wrong parity byte.
    pd_cnt = 0;
    send(8'h0D); send(8'hAA); send(8'h55); send(8'h01); send(8'h00);
    idle(1);
    check_val("badpar.err_with_pd", {o_pd, o_err}, 2'b11);
    idle(2);
    check_val("badpar.err_hold", o_err, 1'b1);
    check_val("badpar.pd_cnt", pd_cnt, 1);
    exp_q = '{8'h0D, 8'hAA, 8'h55, 8'h01, 8'h00};
    check_pkt("badpar", 3'b010, 1'b1);

    // Back-pressure: fifo_full[1] for 3 cycles once 0x55 is held.
    pd_cnt = 0;
    send(8'h0D);
    send(8'hAA);
    check_val("stall.err_cleared", o_err, 1'b0);
    send(8'h55);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h01, 3'b010, AllEmpty, None);
      check_val($sformatf("stall.busy%0d", i), {o_busy, o_we}, {1'b1, 3'b000});
    end
    step(1'b1, 8'h01, None, AllEmpty, None);
    check_val("stall.release", {o_busy, o_we, o_dout}, {1'b0, 3'b010, 8'h55});
    send(8'hF3);
    idle(3);
    check_val("stall.gap", wq[2].cyc - wq[1].cyc, 4);
    check_val("stall.pd", {pd_cnt[1:0], pd_err}, {2'd1, 1'b0});
    exp_q = '{8'h0D, 8'hAA, 8'h55, 8'h01, 8'hF3};
    check_pkt("stall", 3'b010, 1'b0);

    // Header 0x06 to addr 2 while fifo_empty[2]=0 for 4 cycles; parity 06^BB = BD.
    pd_cnt = 0;
    step(1'b1, 8'h06, None, 3'b011, None);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hBB, None, 3'b011, None);
      check_val($sformatf("wait.busy%0d", i), {o_busy, o_we}, {1'b1, 3'b000});
    end
    step(1'b1, 8'hBB, None, AllEmpty, None);
    check_val("wait.busy_rise", {o_busy, o_we}, {1'b1, 3'b000});
    step(1'b1, 8'hBB, None, AllEmpty, None);
    check_val("wait.hdr_write", {o_busy, o_we, o_lfd, o_dout}, {1'b0, 3'b100, 1'b1, 8'h06});
    send(8'hBD);
    idle(3);
    check_val("wait.pd", {pd_cnt[1:0], pd_err}, {2'd1, 1'b0});
    exp_q = '{8'h06, 8'hBB, 8'hBD};
    check_pkt("wait", 3'b100, 1'b1);

    // Header 0x07: addr 3, len 1 -> two more bytes dropped, no writes.
    pd_cnt = 0;
    send(8'h07);
    send(8'h11);
    check_val("disc.busy0", o_busy, 1'b0);
    send(8'h22);
    check_val("disc.busy1", o_busy, 1'b0);
    idle(2);
    check_val("disc.nowrites", wq.size(), 0);
    // A len-0 packet to addr 0 proves the controller is back in DECODE.
    send(8'h00); send(8'h00);
    idle(3);
    check_val("disc.next_pd", {pd_cnt[1:0], pd_err}, {2'd1, 1'b0});
    exp_q = '{8'h00, 8'h00};
    check_pkt("disc.next", 3'b001, 1'b1);

    // soft_reset[1] while 0x55 is accepted: rest of packet swallowed.
    pd_cnt = 0;
    send(8'h0D);
    step(1'b1, 8'hAA, None, AllEmpty, 3'b001);  // other destination's abort: ignored
    step(1'b1, 8'h55, None, AllEmpty, 3'b010);
    send(8'h01);
    check_val("sr.busy0", {o_busy, o_we}, {1'b0, 3'b000});
    send(8'hF3);
    check_val("sr.busy1", {o_busy, o_we}, {1'b0, 3'b000});
    idle(2);
    check_val("sr.no_pd", pd_cnt, 0);
    exp_q = '{8'h0D, 8'hAA};
    check_pkt("sr", 3'b010, 1'b1);
    send(8'h01); send(8'h01);
    idle(3);
    check_val("sr.next_pd", {pd_cnt[1:0], pd_err}, {2'd1, 1'b0});
    exp_q = '{8'h01, 8'h01};
    check_pkt("sr.next", 3'b010, 1'b1);

    // Reset for 2 cycles mid-payload.
    send(8'h0D);
    send(8'hAA);
    reset = 1'b1;
    step(1'b1, 8'h55, None, AllEmpty, None);
    wq.delete();
    step(1'b1, 8'h55, None, AllEmpty, None);
    chk_idle_outputs("rst.mid");
    reset = 1'b0;
    idle(1);
    chk_idle_outputs("rst.after");
    check_val("rst.nowrites", wq.size(), 0);
    pd_cnt = 0;
    send(8'h0D); send(8'hAA); send(8'h55); send(8'h01); send(8'hF3);
    idle(3);
    check_val("rst.next_pd", {pd_cnt[1:0], pd_err}, {2'd1, 1'b0});
    exp_q = '{8'h0D, 8'hAA, 8'h55, 8'h01, 8'hF3};
    check_pkt("rst.next", 3'b010, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
